// File: rtl/wb_pkg.sv
// Shared writeback queue definitions: write codes, link register index
// and the packed entry format stored in the queue.
package wb_pkg;

  localparam logic [1:0] WB_NONE = 2'b00;
  localparam logic [1:0] WB_LINK = 2'b01;
  localparam logic [1:0] WB_REG1 = 2'b10;
  localparam logic [1:0] WB_REG2 = 2'b11;

  localparam logic [4:0] REG_LINK = 5'd31;

  typedef struct packed {
    logic [1:0]  code;
    logic [4:0]  index;
    logic [31:0] data;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/writeback_queue_if.sv
// Producer/register-file bundle for writeback_queue: request handshake,
// hold/flush controls, write port outputs, occupancy, optional bypass
// (WB_QUEUE_BYPASS_EN). master = environment side, slave = queue side.
interface writeback_queue_if #(
  parameter int DEPTH = 4
);

  logic                         in_valid;
  logic                         in_ready;
  logic [1:0]                   in_code;
  logic [4:0]                   in_index;
  logic [31:0]                  in_data;
  logic                         hold;
  logic                         flush;
  logic [1:0]                   out_reg_write;
  logic [4:0]                   out_index;
  logic [31:0]                  out_data;
  logic [$clog2(DEPTH+1)-1:0]   count;
`ifdef WB_QUEUE_BYPASS_EN
  logic [4:0]                   byp_index_a;
  logic [4:0]                   byp_index_b;
  logic                         byp_hit_a;
  logic                         byp_hit_b;
  logic [31:0]                  byp_data_a;
  logic [31:0]                  byp_data_b;
`endif

  modport master (
    output in_valid, in_code, in_index, in_data,
    output hold, flush,
    input  in_ready, out_reg_write, out_index, out_data, count
`ifdef WB_QUEUE_BYPASS_EN
    ,
    output byp_index_a, byp_index_b,
    input  byp_hit_a, byp_hit_b, byp_data_a, byp_data_b
`endif
  );

  modport slave (
    input  in_valid, in_code, in_index, in_data,
    input  hold, flush,
    output in_ready, out_reg_write, out_index, out_data, count
`ifdef WB_QUEUE_BYPASS_EN
    ,
    input  byp_index_a, byp_index_b,
    output byp_hit_a, byp_hit_b, byp_data_a, byp_data_b
`endif
  );

endinterface

// File: rtl/wb_fifo.sv
// Generic synchronous FIFO (power-of-two DEPTH, W-bit entries), sync
// active-low rst, flush; exposes read pointer and raw slots for lookups.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [W-1:0]                 wdata,
  output logic [W-1:0]                 rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH)-1:0]     rd_ptr,
  output logic [DEPTH-1:0][W-1:0]      slots
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wr_q;
  logic [PW-1:0]           rd_q;
  logic [CW-1:0]           cnt;
  logic                    push_ok;
  logic                    pop_ok;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_q];
  assign count   = cnt;
  assign rd_ptr  = rd_q;
  assign slots   = mem;

  always_ff @(posedge clk) begin
    if (rst && !flush && push_ok) begin
      mem[wr_q] <= wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt  <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + PW'(1);
      if (pop_ok)  rd_q <= rd_q + PW'(1);
      if (push_ok && !pop_ok) begin
        cnt <= cnt + CW'(1);
      end else if (pop_ok && !push_ok) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// Register-file writeback queue: buffers write requests, drains one per
// cycle unless held; optional bypass lookup under WB_QUEUE_BYPASS_EN.
module writeback_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  writeback_queue_if.slave wq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  wb_entry_t               in_ent;
  wb_entry_t               head;
  logic [ENTRY_W-1:0]      head_bits;
  logic [DEPTH-1:0][ENTRY_W-1:0] slots;
  logic [PW-1:0]           rd_ptr;
  logic [CW-1:0]           cnt;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic                    out_valid;
  logic [4:0]              last_index;
  logic [31:0]             last_data;

  always_comb begin
    in_ent.code  = wq.in_code;
    in_ent.index = (wq.in_code == WB_LINK) ? REG_LINK : wq.in_index;
    in_ent.data  = wq.in_data;
  end

  // Code 00 requests are accepted but never stored.
  assign push = wq.in_valid & ~full & ~wq.flush & (wq.in_code != WB_NONE);

  assign head      = wb_entry_t'(head_bits);
  assign out_valid = rst & ~empty & ~wq.hold & ~wq.flush;
  assign pop       = out_valid;

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (wq.flush),
    .wdata (in_ent),
    .rdata (head_bits),
    .count (cnt),
    .full  (full),
    .empty (empty),
    .rd_ptr(rd_ptr),
    .slots (slots)
  );

  // Idle outputs keep showing the last entry written.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_index <= '0;
      last_data  <= '0;
    end else if (pop) begin
      last_index <= head.index;
      last_data  <= head.data;
    end
  end

  assign wq.in_ready      = ~full;
  assign wq.count         = cnt;
  assign wq.out_reg_write = out_valid ? head.code  : WB_NONE;
  assign wq.out_index     = out_valid ? head.index : last_index;
  assign wq.out_data      = out_valid ? head.data  : last_data;

`ifdef WB_QUEUE_BYPASS_EN
  wb_entry_t     slot;
  logic [PW-1:0] sp;

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    wq.byp_hit_a  = 1'b0;
    wq.byp_hit_b  = 1'b0;
    wq.byp_data_a = '0;
    wq.byp_data_b = '0;
    slot          = '0;
    sp            = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sp   = rd_ptr + PW'(i);
      slot = wb_entry_t'(slots[sp]);
      if (CW'(i) < cnt) begin
        if (slot.index == wq.byp_index_a) begin
          wq.byp_hit_a  = 1'b1;
          wq.byp_data_a = slot.data;
        end
        if (slot.index == wq.byp_index_b) begin
          wq.byp_hit_b  = 1'b1;
          wq.byp_data_b = slot.data;
        end
      end
    end
  end
`else
  logic unused_snap;
  assign unused_snap = ^{slots, rd_ptr};
`endif

endmodule
